// File: rtl/carry_accumulator.sv
// carry_accumulator
// Collects BEATS words from an upstream ripple-carry adder, keeps a running
// total, a sticky overflow flag and a count of words that arrived with a
// carry-out, then presents the burst result until downstream takes it.
//
// Build option: define CARRY_ACC_SATURATE_EN to clamp the total to all-ones
// on overflow. When it is left undefined, the total wraps modulo 2^N.
// The overflow flag behaves the same way in both builds.

module carry_accumulator #(
    parameter int N     = 16,
    parameter int BEATS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_sum,
    input  logic         in_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_acc,
    output logic         out_ovf,
    output logic [7:0]   out_carries
);

    typedef enum logic {
        ACC,
        HOLD
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] acc_q, acc_d;
    logic         ovf_q, ovf_d;
    logic [7:0]   carries_q, carries_d;
    logic [7:0]   beatCnt_q, beatCnt_d;

    logic [N:0]   sumWide;
    logic         lastBeat;

    // The top bit of the widened sum is the overflow of this beat.
    assign sumWide  = {1'b0, acc_q} + {1'b0, in_sum};
    assign lastBeat = (beatCnt_q == 8'(BEATS - 1));

    // Handshake flags come straight from the state register.
    assign in_ready    = (state_q == ACC);
    assign out_valid   = (state_q == HOLD);
    assign out_acc     = acc_q;
    assign out_ovf     = ovf_q;
    assign out_carries = carries_q;

    // Next-state logic: accumulate accepted beats in ACC, wait for the
    // downstream handshake in HOLD and then start the next burst from zero.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        carries_d = carries_q;
        beatCnt_d = beatCnt_q;

        case (state_q)
            ACC: begin
                if (in_valid) begin
`ifdef CARRY_ACC_SATURATE_EN
                    // Once clamped, any nonzero add overflows again and a
                    // zero add leaves all-ones, so the clamp holds for the
                    // remainder of the burst.
                    if (sumWide[N]) begin
                        acc_d = '1;
                    end else begin
                        acc_d = sumWide[N-1:0];
                    end
`else
                    acc_d = sumWide[N-1:0];
`endif
                    if (sumWide[N]) begin
                        ovf_d = 1'b1;
                    end
                    if (in_cout) begin
                        carries_d = carries_q + 8'd1;
                    end
                    beatCnt_d = beatCnt_q + 8'd1;
                    if (lastBeat) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d   = ACC;
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                    carries_d = 8'd0;
                    beatCnt_d = 8'd0;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // State register; reset discards any partial or unconsumed burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACC;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            carries_q <= 8'd0;
            beatCnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            carries_q <= carries_d;
            beatCnt_q <= beatCnt_d;
        end
    end

endmodule

// File: tb/tb_carry_accumulator.sv
// tb_carry_accumulator
// Drives bursts into carry_accumulator, predicts each burst result with a
// small arithmetic model and queues it; results are popped and compared when
// the DUT presents out_valid. Honours CARRY_ACC_SATURATE_EN like the DUT.

module tb_carry_accumulator;

    typedef struct packed {
        logic [15:0] acc;
        logic        ovf;
        logic [7:0]  carries;
    } result_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sum;
    logic        in_cout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_acc;
    logic        out_ovf;
    logic [7:0]  out_carries;

    result_t expQ[$];
    int      testCount;
    int      failCount;

    carry_accumulator #(
        .N     (16),
        .BEATS (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .in_cout     (in_cout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_acc     (out_acc),
        .out_ovf     (out_ovf),
        .out_carries (out_carries)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a run that never finishes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one word at the current negedge; it is accepted on the next posedge.
    task automatic sendBeat(input logic [15:0] w, input logic c);
        checkOutput("in_ready_before_beat", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_sum   = w;
        in_cout  = c;
        @(posedge clk);
    endtask

    // Predicts a four-word burst, queues the expected result and drives it.
    // stallAt >= 0 inserts idle cycles before that beat.
    task automatic applyStimulus(input logic [63:0] words, input logic [3:0] couts,
                                 input int stallAt);
        int unsigned model;
        int unsigned s;
        logic        ov;
        int          carries;
        logic [15:0] partial[4];
        result_t     r;

        model   = 0;
        ov      = 1'b0;
        carries = 0;
        for (int i = 0; i < 4; i++) begin
            s = model + int'(words[16*i +: 16]);
            if (s > 32'h0000_FFFF) begin
                ov = 1'b1;
`ifdef CARRY_ACC_SATURATE_EN
                model = 32'h0000_FFFF;
`else
                model = s & 32'h0000_FFFF;
`endif
            end else begin
                model = s;
            end
            if (couts[i]) carries++;
            partial[i] = model[15:0];
        end
        r.acc     = model[15:0];
        r.ovf     = ov;
        r.carries = 8'(carries);
        expQ.push_back(r);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == stallAt) begin
                in_valid = 1'b0;
                in_sum   = 16'hDEAD;
                in_cout  = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("stall_acc", {16'd0, out_acc}, {16'd0, partial[i-1]});
                end
            end
            if (i > 0) begin
                checkOutput("running_acc", {16'd0, out_acc}, {16'd0, partial[i-1]});
            end
            sendBeat(words[16*i +: 16], couts[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_cout  = 1'b0;
    endtask

    // Pops the oldest expected result and compares it against the presented
    // burst; optionally holds off downstream for holdCycles with in_valid high.
    task automatic collectResult(input int holdCycles);
        result_t     r;
        logic [15:0] heldAcc;

        checkOutput("latency_out_valid", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        checkOutput("queue_nonempty", {31'd0, expQ.size() != 0}, 32'd1);
        if (expQ.size() == 0) return;
        r = expQ.pop_front();
        checkOutput("out_acc", {16'd0, out_acc}, {16'd0, r.acc});
        checkOutput("out_ovf", {31'd0, out_ovf}, {31'd0, r.ovf});
        checkOutput("out_carries", {24'd0, out_carries}, {24'd0, r.carries});

        heldAcc = r.acc;
        if (holdCycles > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_sum    = 16'h1234;
            in_cout   = 1'b1;
            repeat (holdCycles) begin
                @(negedge clk);
                checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
                checkOutput("hold_acc", {16'd0, out_acc}, {16'd0, heldAcc});
                checkOutput("hold_carries", {24'd0, out_carries}, {24'd0, r.carries});
            end
            in_valid = 1'b0;
            in_cout  = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("post_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("post_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("post_acc", {16'd0, out_acc}, 32'd0);
        checkOutput("post_ovf", {31'd0, out_ovf}, 32'd0);
        checkOutput("post_carries", {24'd0, out_carries}, 32'd0);
    endtask

    // Checks every output against its reset value.
    task automatic checkReset(input string tag);
        checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        checkOutput({tag, "_acc"}, {16'd0, out_acc}, 32'd0);
        checkOutput({tag, "_ovf"}, {31'd0, out_ovf}, 32'd0);
        checkOutput({tag, "_carries"}, {24'd0, out_carries}, 32'd0);
    endtask

    // Test sequence.
    initial begin
        logic [63:0] rw;

        testCount = 0;
        failCount = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = 16'd0;
        in_cout   = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;

        // Basic burst 1,2,3,4.
        applyStimulus({16'd4, 16'd3, 16'd2, 16'd1}, 4'b0000, -1);
        collectResult(0);

        // Overflow burst.
        applyStimulus({16'h0000, 16'h0000, 16'h0002, 16'hFFFF}, 4'b0000, -1);
        collectResult(0);

        // Carry count on beats 2 and 4, with a stall before beat 3.
        applyStimulus({16'd40, 16'd30, 16'd20, 16'd10}, 4'b1010, 2);
        collectResult(0);

        // Backpressure in HOLD for 5 cycles.
        applyStimulus({16'h0400, 16'h0300, 16'h0200, 16'h0100}, 4'b0001, -1);
        collectResult(5);

        // Mid-burst reset after two accepted beats that set ovf and carries.
        @(negedge clk);
        sendBeat(16'hFFFF, 1'b1);
        @(negedge clk);
        sendBeat(16'h0002, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_cout  = 1'b0;
        checkOutput("pre_reset_ovf", {31'd0, out_ovf}, 32'd1);
        rst = 1'b1;
        #1;
        checkReset("async_reset");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus({16'd5, 16'd5, 16'd5, 16'd5}, 4'b0000, -1);
        collectResult(0);

        // Two random bursts.
        for (int n = 0; n < 2; n++) begin
            rw = {$urandom(), $urandom()};
            applyStimulus(rw, 4'($urandom_range(0, 15)), 1);
            collectResult(n + 1);
        end

        checkOutput("queue_drained", expQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/carry_accumulator.md
CARRY_ACCUMULATOR -- requirements
Module: carry_accumulator

Interface
REQ-001 Parameter N SHALL default to 16 and sets the data width, matching the upstream ripple-carry adder width.
REQ-002 Parameter BEATS SHALL default to 4 and sets the number of accepted words per burst (legal range 2..255).
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide, and is the reset: asynchronous, active-high.
REQ-005 Port in_valid SHALL be an input, 1 bit wide, and marks the upstream adder result as valid.
REQ-006 Port in_ready SHALL be an output, 1 bit wide, and indicates that the block accepts a word this cycle.
REQ-007 Port in_sum SHALL be an input, N bits wide, and carries the sum word from the upstream adder.
REQ-008 Port in_cout SHALL be an input, 1 bit wide, and carries the carry-out from the upstream adder.
REQ-009 Port out_valid SHALL be an output, 1 bit wide, and indicates that the burst result is presented.
REQ-010 Port out_ready SHALL be an input, 1 bit wide, and indicates that downstream accepts the result.
REQ-011 Port out_acc SHALL be an output, N bits wide, and carries the accumulated total.
REQ-012 Port out_ovf SHALL be an output, 1 bit wide, and is a sticky overflow flag for the burst.
REQ-013 Port out_carries SHALL be an output, 8 bits wide, and counts accepted words whose in_cout was 1.

Function
REQ-014 The block SHALL implement two states: ACC (collecting words) and HOLD (presenting the result).
REQ-015 in_ready SHALL be combinational and equal to (state == ACC); in_ready SHALL be 0 in HOLD.
REQ-016 A beat is accepted when in_valid & in_ready are both 1; only then do acc, ovf, the carry count and the beat count update.
REQ-017 On an accepted beat, acc SHALL be set to acc + in_sum, computed at N+1 bits.
REQ-018 If bit N of that N+1-bit sum is 1, ovf SHALL be set to 1 and SHALL stay 1 until the burst clears.
REQ-019 On an accepted beat, out_carries SHALL increment by 1 when in_cout = 1 and is otherwise unchanged.
REQ-020 The BEATS-th accepted beat SHALL move the state to HOLD; out_valid SHALL be 1 in the following cycle with the final values.
REQ-021 Latency SHALL be 1 cycle from the last accepted beat to out_valid.
REQ-022 out_valid SHALL equal (state == HOLD), and all outputs SHALL be registered.
REQ-023 In HOLD, out_acc, out_ovf and out_carries SHALL be held stable until out_valid & out_ready.
REQ-024 In HOLD, in_valid SHALL be ignored.
REQ-025 When out_valid & out_ready, the state SHALL return to ACC and acc, ovf, carry count and beat count SHALL clear to 0.
REQ-026 After that handshake, in_ready SHALL rise in the next cycle; a word SHALL NOT be accepted in the handshake cycle.
REQ-027 In ACC, out_acc SHALL show the running total.
REQ-028 Stalls from in_valid = 0 SHALL not alter any state.

Reset
REQ-029 rst = 1 SHALL immediately (asynchronously) force: state ACC, out_acc 0, out_ovf 0, out_carries 0, beat count 0, out_valid 0, in_ready 1.
REQ-030 Reset asserted mid-burst or in HOLD SHALL discard the partial or unconsumed result; the next burst starts from 0.

Configuration
REQ-031 The macro CARRY_ACC_SATURATE_EN SHALL select overflow handling.
REQ-032 With CARRY_ACC_SATURATE_EN defined, an overflowing add SHALL clamp acc to all-ones, and acc SHALL remain all-ones for the rest of the burst.
REQ-033 Without CARRY_ACC_SATURATE_EN, acc SHALL wrap modulo 2^N.
REQ-034 out_ovf behaviour SHALL be identical in both builds.

Verification (N=16, BEATS=4)
REQ-035 Reset check: assert rst -> out_valid=0, in_ready=1, out_acc=0x0000, out_ovf=0, out_carries=0.
REQ-036 Basic burst: beats 1,2,3,4 with in_cout=0 -> one cycle after the 4th accept, out_valid=1, out_acc=0x000A, out_ovf=0, out_carries=0.
REQ-037 Overflow burst: beats 0xFFFF,0x0002,0x0000,0x0000 -> wrap build gives out_acc=0x0001, out_ovf=1; saturate build gives out_acc=0xFFFF, out_ovf=1.
REQ-038 Carry count: in_cout=1 on beats 2 and 4 -> out_carries=2.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles in HOLD with in_valid=1 -> outputs stable, in_ready=0, nothing accepted; then out_ready=1 -> ACC, and in_ready=1 in the next cycle.
REQ-040 Mid-burst reset: pulse rst after 2 accepted beats -> all outputs reset; a following burst 5,5,5,5 yields out_acc=0x0014.
